// File: rtl/elevator_pkg.sv
// Shared elevator definitions: default geometry, controller motion codes and
// the per-button call FSM state type.
package elevator_pkg;

  localparam int unsigned NUM_FLOORS     = 4;
  localparam int unsigned DEB_CYCLES_DEF = 2;

  localparam logic [1:0] AC_IDLE = 2'b00;
  localparam logic [1:0] AC_UP   = 2'b01;
  localparam logic [1:0] AC_DN   = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StDeb,
    StPend,
    StHold
  } call_state_e;

endpackage

// File: rtl/call_latch.sv
// One hall/car button: debounce, latch the call until its floor is served,
// then hold off re-registering until the button is released.
module call_latch
  import elevator_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic served,
  output logic req,
  output logic req_next
);

  call_state_e state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (btn) begin
          if (served) begin
            state_d = StHold;
          end else if (DEB_CYCLES <= 1) begin
            state_d = StPend;
          end else begin
            state_d = StDeb;
            cnt_d   = 3'd1;
          end
        end
      end
      StDeb: begin
        if (served) begin
          state_d = StHold;
          cnt_d   = '0;
        end else if (!btn) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q + 3'd1 >= 3'(DEB_CYCLES)) begin
          state_d = StPend;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StPend: begin
        if (served) state_d = StHold;
      end
      StHold: begin
        // Service swallows the press; only a release re-arms the button.
        if (!btn) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign req      = (state_q == StPend);
  assign req_next = (state_d == StPend);

endmodule

// File: rtl/call_panel.sv
// Elevator call panel: per-button call latches for hall up/down and car
// buttons, plus the combined per-floor request vector and its count.
module call_panel #(
  parameter int unsigned NUM_FLOORS = elevator_pkg::NUM_FLOORS,
  parameter int unsigned DEB_CYCLES = elevator_pkg::DEB_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] btn_up,
  input  logic [NUM_FLOORS-1:0] btn_dn,
  input  logic [NUM_FLOORS-1:0] btn_car,
  input  logic [1:0]            AC,
  input  logic [2:0]            DISP,
  input  logic                  open,
  output logic [NUM_FLOORS-1:0] U,
  output logic [NUM_FLOORS-1:0] D,
  output logic [NUM_FLOORS-1:0] F,
  output logic [NUM_FLOORS-1:0] S,
  output logic [2:0]            pending
);

  logic [NUM_FLOORS-1:0] served;
  logic [NUM_FLOORS-1:0] up_btn, dn_btn;
  logic [NUM_FLOORS-1:0] up_next, dn_next, car_next, s_next;
  logic [2:0]            pending_q, pending_d;
  logic                  unused_inputs;

  // No up call from the top floor and no down call from the bottom floor.
  assign up_btn = {1'b0, btn_up[NUM_FLOORS-2:0]};
  assign dn_btn = {btn_dn[NUM_FLOORS-1:1], 1'b0};

  // Service clears calls regardless of motion, so AC is not consulted.
  assign unused_inputs = ^{AC, btn_up[NUM_FLOORS-1], btn_dn[0]};

  for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_floor
    assign served[i] = open && (DISP == 3'(i));

    call_latch #(.DEB_CYCLES(DEB_CYCLES)) u_up (
      .clk     (clk),
      .reset   (reset),
      .btn     (up_btn[i]),
      .served  (served[i]),
      .req     (U[i]),
      .req_next(up_next[i])
    );

    call_latch #(.DEB_CYCLES(DEB_CYCLES)) u_dn (
      .clk     (clk),
      .reset   (reset),
      .btn     (dn_btn[i]),
      .served  (served[i]),
      .req     (D[i]),
      .req_next(dn_next[i])
    );

    call_latch #(.DEB_CYCLES(DEB_CYCLES)) u_car (
      .clk     (clk),
      .reset   (reset),
      .btn     (btn_car[i]),
      .served  (served[i]),
      .req     (F[i]),
      .req_next(car_next[i])
    );
  end

  assign S      = U | D | F;
  assign s_next = up_next | dn_next | car_next;

  // Count from next-state S so pending moves on the same edge as U/D/F.
  always_comb begin
    pending_d = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      pending_d = pending_d + 3'(s_next[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  assign pending = pending_q;

endmodule

// File: tb/tb_call_panel.sv
// Self-checking bench for call_panel (4 floors, 2-cycle debounce): each row
// drives one cycle of inputs and queues the outputs expected after that edge.
module tb_call_panel;

  typedef struct packed {
    logic [3:0] u;
    logic [3:0] d;
    logic [3:0] f;
    logic [3:0] s;
    logic [2:0] p;
  } obs_t;

  typedef struct packed {
    logic       rst_n;
    logic [3:0] up;
    logic [3:0] dn;
    logic [3:0] car;
    logic [2:0] disp;
    logic       opn;
    obs_t       exp;
  } row_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_up, btn_dn, btn_car;
  logic [1:0] AC;
  logic [2:0] DISP;
  logic       open;
  logic [3:0] U, D, F, S;
  logic [2:0] pending;

  obs_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  call_panel #(.NUM_FLOORS(4), .DEB_CYCLES(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .btn_up (btn_up),
    .btn_dn (btn_dn),
    .btn_car(btn_car),
    .AC     (AC),
    .DISP   (DISP),
    .open   (open),
    .U      (U),
    .D      (D),
    .F      (F),
    .S      (S),
    .pending(pending)
  );

  function automatic obs_t mk(logic [3:0] u, logic [3:0] d, logic [3:0] f, logic [2:0] p);
    obs_t o;
    o.u = u; o.d = d; o.f = f; o.s = u | d | f; o.p = p;
    return o;
  endfunction

  function automatic row_t row(logic rst_n, logic [3:0] up, logic [3:0] dn, logic [3:0] car,
                               logic [2:0] disp, logic opn, obs_t exp);
    row_t r;
    r.rst_n = rst_n; r.up = up; r.dn = dn; r.car = car;
    r.disp = disp; r.opn = opn; r.exp = exp;
    return r;
  endfunction

  task automatic test_reset();
    row_t rows[$];
    obs_t e, got;
    rows.push_back(row(1'b0, 4'hf, 4'hf, 4'hf, 3'd0, 1'b0, mk(4'h0, 4'h0, 4'h0, 3'd0)));
    rows.push_back(row(1'b0, 4'h0, 4'h0, 4'h0, 3'd0, 1'b0, mk(4'h0, 4'h0, 4'h0, 3'd0)));
    rows.push_back(row(1'b1, 4'h0, 4'h0, 4'h0, 3'd0, 1'b0, mk(4'h0, 4'h0, 4'h0, 3'd0)));
    foreach (rows[k]) begin
      reset = rows[k].rst_n; btn_up = rows[k].up; btn_dn = rows[k].dn; btn_car = rows[k].car;
      DISP = rows[k].disp; open = rows[k].opn; AC = 2'(k);
      exp_q.push_back(rows[k].exp);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      got = {U, D, F, S, pending};
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL reset step %0d: U/D/F/S/pending got %h/%h/%h/%h/%0d, expected %h/%h/%h/%h/%0d",
                 k, got.u, got.d, got.f, got.s, got.p, e.u, e.d, e.f, e.s, e.p);
      end
    end
  endtask

  task automatic test_up_latch();
    row_t rows[$];
    obs_t e, got;
    rows.push_back(row(1'b1, 4'h2, 4'h0, 4'h0, 3'd0, 1'b0, mk(4'h0, 4'h0, 4'h0, 3'd0)));
    rows.push_back(row(1'b1, 4'h2, 4'h0, 4'h0, 3'd0, 1'b0, mk(4'h2, 4'h0, 4'h0, 3'd1)));
    rows.push_back(row(1'b1, 4'h2, 4'h0, 4'h0, 3'd0, 1'b0, mk(4'h2, 4'h0, 4'h0, 3'd1)));
    rows.push_back(row(1'b1, 4'h0, 4'h0, 4'h0, 3'd0, 1'b0, mk(4'h2, 4'h0, 4'h0, 3'd1)));
    rows.push_back(row(1'b1, 4'h0, 4'h0, 4'h0, 3'd0, 1'b0, mk(4'h2, 4'h0, 4'h0, 3'd1)));
    foreach (rows[k]) begin
      reset = rows[k].rst_n; btn_up = rows[k].up; btn_dn = rows[k].dn; btn_car = rows[k].car;
      DISP = rows[k].disp; open = rows[k].opn; AC = 2'b01;
      exp_q.push_back(rows[k].exp);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      got = {U, D, F, S, pending};
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL up_latch step %0d: U/D/F/S/pending got %h/%h/%h/%h/%0d, expected %h/%h/%h/%h/%0d",
                 k, got.u, got.d, got.f, got.s, got.p, e.u, e.d, e.f, e.s, e.p);
      end
    end
  endtask

  task automatic test_short_press();
    row_t rows[$];
    obs_t e, got;
    rows.push_back(row(1'b1, 4'h0, 4'h8, 4'h0, 3'd0, 1'b0, mk(4'h2, 4'h0, 4'h0, 3'd1)));
    for (int j = 0; j < 3; j++)
      rows.push_back(row(1'b1, 4'h0, 4'h0, 4'h0, 3'd0, 1'b0, mk(4'h2, 4'h0, 4'h0, 3'd1)));
    foreach (rows[k]) begin
      reset = rows[k].rst_n; btn_up = rows[k].up; btn_dn = rows[k].dn; btn_car = rows[k].car;
      DISP = rows[k].disp; open = rows[k].opn; AC = 2'b00;
      exp_q.push_back(rows[k].exp);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      got = {U, D, F, S, pending};
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL short_press step %0d: U/D/F/S/pending got %h/%h/%h/%h/%0d, expected %h/%h/%h/%h/%0d",
                 k, got.u, got.d, got.f, got.s, got.p, e.u, e.d, e.f, e.s, e.p);
      end
    end
  endtask

  task automatic test_service();
    row_t rows[$];
    obs_t e, got;
    rows.push_back(row(1'b1, 4'h0, 4'h0, 4'h4, 3'd0, 1'b0, mk(4'h2, 4'h0, 4'h0, 3'd1)));
    rows.push_back(row(1'b1, 4'h0, 4'h0, 4'h4, 3'd0, 1'b0, mk(4'h2, 4'h0, 4'h4, 3'd2)));
    // Out-of-range floor number must serve nothing.
    rows.push_back(row(1'b1, 4'h0, 4'h0, 4'h0, 3'd5, 1'b1, mk(4'h2, 4'h0, 4'h4, 3'd2)));
    rows.push_back(row(1'b1, 4'h0, 4'h0, 4'h0, 3'd1, 1'b1, mk(4'h0, 4'h0, 4'h4, 3'd1)));
    rows.push_back(row(1'b1, 4'h0, 4'h0, 4'h0, 3'd1, 1'b0, mk(4'h0, 4'h0, 4'h4, 3'd1)));
    foreach (rows[k]) begin
      reset = rows[k].rst_n; btn_up = rows[k].up; btn_dn = rows[k].dn; btn_car = rows[k].car;
      DISP = rows[k].disp; open = rows[k].opn; AC = 2'b10;
      exp_q.push_back(rows[k].exp);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      got = {U, D, F, S, pending};
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL service step %0d: U/D/F/S/pending got %h/%h/%h/%h/%0d, expected %h/%h/%h/%h/%0d",
                 k, got.u, got.d, got.f, got.s, got.p, e.u, e.d, e.f, e.s, e.p);
      end
    end
  endtask

  task automatic test_held_service();
    row_t rows[$];
    obs_t e, got;
    rows.push_back(row(1'b1, 4'h0, 4'h0, 4'h4, 3'd0, 1'b0, mk(4'h0, 4'h0, 4'h4, 3'd1)));
    rows.push_back(row(1'b1, 4'h0, 4'h0, 4'h4, 3'd2, 1'b1, mk(4'h0, 4'h0, 4'h0, 3'd0)));
    rows.push_back(row(1'b1, 4'h0, 4'h0, 4'h4, 3'd2, 1'b0, mk(4'h0, 4'h0, 4'h0, 3'd0)));
    rows.push_back(row(1'b1, 4'h0, 4'h0, 4'h4, 3'd2, 1'b0, mk(4'h0, 4'h0, 4'h0, 3'd0)));
    rows.push_back(row(1'b1, 4'h0, 4'h0, 4'h0, 3'd2, 1'b0, mk(4'h0, 4'h0, 4'h0, 3'd0)));
    rows.push_back(row(1'b1, 4'h0, 4'h0, 4'h4, 3'd2, 1'b0, mk(4'h0, 4'h0, 4'h0, 3'd0)));
    rows.push_back(row(1'b1, 4'h0, 4'h0, 4'h4, 3'd2, 1'b0, mk(4'h0, 4'h0, 4'h4, 3'd1)));
    rows.push_back(row(1'b1, 4'h0, 4'h0, 4'h0, 3'd2, 1'b0, mk(4'h0, 4'h0, 4'h4, 3'd1)));
    foreach (rows[k]) begin
      reset = rows[k].rst_n; btn_up = rows[k].up; btn_dn = rows[k].dn; btn_car = rows[k].car;
      DISP = rows[k].disp; open = rows[k].opn; AC = 2'b11;
      exp_q.push_back(rows[k].exp);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      got = {U, D, F, S, pending};
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL held_service step %0d: U/D/F/S/pending got %h/%h/%h/%h/%0d, expected %h/%h/%h/%h/%0d",
                 k, got.u, got.d, got.f, got.s, got.p, e.u, e.d, e.f, e.s, e.p);
      end
    end
  endtask

  task automatic test_ignored_buttons();
    row_t rows[$];
    obs_t e, got;
    rows.push_back(row(1'b0, 4'h0, 4'h0, 4'h0, 3'd0, 1'b0, mk(4'h0, 4'h0, 4'h0, 3'd0)));
    for (int j = 0; j < 10; j++)
      rows.push_back(row(1'b1, 4'h8, 4'h1, 4'h0, 3'd0, 1'b0, mk(4'h0, 4'h0, 4'h0, 3'd0)));
    rows.push_back(row(1'b1, 4'h0, 4'h0, 4'h0, 3'd0, 1'b0, mk(4'h0, 4'h0, 4'h0, 3'd0)));
    foreach (rows[k]) begin
      reset = rows[k].rst_n; btn_up = rows[k].up; btn_dn = rows[k].dn; btn_car = rows[k].car;
      DISP = rows[k].disp; open = rows[k].opn; AC = 2'b00;
      exp_q.push_back(rows[k].exp);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      got = {U, D, F, S, pending};
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL ignored_buttons step %0d: U/D/F/S/pending got %h/%h/%h/%h/%0d, expected %h/%h/%h/%h/%0d",
                 k, got.u, got.d, got.f, got.s, got.p, e.u, e.d, e.f, e.s, e.p);
      end
    end
  endtask

  task automatic test_reset_mid();
    row_t rows[$];
    obs_t e, got;
    rows.push_back(row(1'b1, 4'h1, 4'h4, 4'h2, 3'd0, 1'b0, mk(4'h0, 4'h0, 4'h0, 3'd0)));
    rows.push_back(row(1'b1, 4'h1, 4'h4, 4'h2, 3'd0, 1'b0, mk(4'h1, 4'h4, 4'h2, 3'd3)));
    rows.push_back(row(1'b1, 4'h0, 4'h0, 4'h2, 3'd0, 1'b0, mk(4'h1, 4'h4, 4'h2, 3'd3)));
    rows.push_back(row(1'b0, 4'h0, 4'h0, 4'h2, 3'd0, 1'b0, mk(4'h0, 4'h0, 4'h0, 3'd0)));
    rows.push_back(row(1'b1, 4'h0, 4'h0, 4'h2, 3'd0, 1'b0, mk(4'h0, 4'h0, 4'h0, 3'd0)));
    rows.push_back(row(1'b1, 4'h0, 4'h0, 4'h2, 3'd0, 1'b0, mk(4'h0, 4'h0, 4'h2, 3'd1)));
    foreach (rows[k]) begin
      reset = rows[k].rst_n; btn_up = rows[k].up; btn_dn = rows[k].dn; btn_car = rows[k].car;
      DISP = rows[k].disp; open = rows[k].opn; AC = 2'b01;
      exp_q.push_back(rows[k].exp);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      got = {U, D, F, S, pending};
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL reset_mid step %0d: U/D/F/S/pending got %h/%h/%h/%h/%0d, expected %h/%h/%h/%h/%0d",
                 k, got.u, got.d, got.f, got.s, got.p, e.u, e.d, e.f, e.s, e.p);
      end
    end
  endtask

  // Press during service, press as service ends, service during debounce.
  task automatic test_back_to_back();
    row_t rows[$];
    obs_t e, got;
    rows.push_back(row(1'b1, 4'h0, 4'h0, 4'h0, 3'd0, 1'b0, mk(4'h0, 4'h0, 4'h2, 3'd1)));
    rows.push_back(row(1'b1, 4'h0, 4'h0, 4'h8, 3'd3, 1'b1, mk(4'h0, 4'h0, 4'h2, 3'd1)));
    rows.push_back(row(1'b1, 4'h0, 4'h0, 4'h8, 3'd3, 1'b0, mk(4'h0, 4'h0, 4'h2, 3'd1)));
    rows.push_back(row(1'b1, 4'h0, 4'h0, 4'h0, 3'd3, 1'b0, mk(4'h0, 4'h0, 4'h2, 3'd1)));
    rows.push_back(row(1'b1, 4'h0, 4'h0, 4'h0, 3'd0, 1'b1, mk(4'h0, 4'h0, 4'h2, 3'd1)));
    rows.push_back(row(1'b1, 4'h0, 4'h0, 4'h1, 3'd0, 1'b0, mk(4'h0, 4'h0, 4'h2, 3'd1)));
    rows.push_back(row(1'b1, 4'h0, 4'h0, 4'h1, 3'd0, 1'b0, mk(4'h0, 4'h0, 4'h3, 3'd2)));
    rows.push_back(row(1'b1, 4'h0, 4'h0, 4'h0, 3'd0, 1'b0, mk(4'h0, 4'h0, 4'h3, 3'd2)));
    rows.push_back(row(1'b1, 4'h4, 4'h0, 4'h0, 3'd0, 1'b0, mk(4'h0, 4'h0, 4'h3, 3'd2)));
    rows.push_back(row(1'b1, 4'h4, 4'h0, 4'h0, 3'd2, 1'b1, mk(4'h0, 4'h0, 4'h3, 3'd2)));
    rows.push_back(row(1'b1, 4'h4, 4'h0, 4'h0, 3'd2, 1'b0, mk(4'h0, 4'h0, 4'h3, 3'd2)));
    rows.push_back(row(1'b1, 4'h0, 4'h0, 4'h0, 3'd2, 1'b0, mk(4'h0, 4'h0, 4'h3, 3'd2)));
    rows.push_back(row(1'b1, 4'h4, 4'h0, 4'h0, 3'd2, 1'b0, mk(4'h0, 4'h0, 4'h3, 3'd2)));
    rows.push_back(row(1'b1, 4'h4, 4'h0, 4'h0, 3'd2, 1'b0, mk(4'h4, 4'h0, 4'h3, 3'd3)));
    rows.push_back(row(1'b1, 4'h0, 4'h0, 4'h0, 3'd2, 1'b0, mk(4'h4, 4'h0, 4'h3, 3'd3)));
    foreach (rows[k]) begin
      reset = rows[k].rst_n; btn_up = rows[k].up; btn_dn = rows[k].dn; btn_car = rows[k].car;
      DISP = rows[k].disp; open = rows[k].opn; AC = 2'b10;
      exp_q.push_back(rows[k].exp);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      got = {U, D, F, S, pending};
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL back_to_back step %0d: U/D/F/S/pending got %h/%h/%h/%h/%0d, expected %h/%h/%h/%h/%0d",
                 k, got.u, got.d, got.f, got.s, got.p, e.u, e.d, e.f, e.s, e.p);
      end
    end
  endtask

  initial begin
    reset = 1'b0; btn_up = '0; btn_dn = '0; btn_car = '0;
    AC = 2'b00; DISP = 3'd0; open = 1'b0;
    test_reset();
    test_up_latch();
    test_short_press();
    test_service();
    test_held_service();
    test_ignored_buttons();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
